// File: rtl/instr_encoder_writer_if.sv
// Request and instruction-memory write handshake bundle for instr_encoder_writer.
// slave: the encoder's view; master: the requester / memory side.
interface instr_encoder_writer_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [11:0]       req_imm;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport slave (
        input  req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, imem_ready,
        output req_ready, imem_we, imem_addr, imem_wdata
    );

    modport master (
        output req_valid, req_op, req_rd, req_rs1, req_rs2, req_imm, imem_ready,
        input  req_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_writer.sv
// Packs mnemonic-level requests into 32-bit instruction words, buffers them and writes
// them sequentially to instruction memory. Optional write checksum: ENC_CHECKSUM_EN.
module instr_encoder_writer #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned DEPTH     = 2,
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  stop,
    instr_encoder_writer_if.slave bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           wr_count,
    output logic [31:0]           checksum
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [6:0] OPC_R    = 7'h00;
    localparam logic [6:0] OPC_I    = 7'h01;
    localparam logic [6:0] OPC_LW   = 7'h02;
    localparam logic [6:0] OPC_SW   = 7'h03;
    localparam logic [6:0] OPC_BR   = 7'h04;
    localparam logic [6:0] OPC_JAL  = 7'h05;
    localparam logic [6:0] OPC_JALR = 7'h06;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_ADDI = 5'd8;
    localparam logic [4:0] OP_ANDI = 5'd9;
    localparam logic [4:0] OP_ORI  = 5'd10;
    localparam logic [4:0] OP_XORI = 5'd11;
    localparam logic [4:0] OP_SLLI = 5'd12;
    localparam logic [4:0] OP_SRLI = 5'd13;
    localparam logic [4:0] OP_SRAI = 5'd14;
    localparam logic [4:0] OP_LW   = 5'd15;
    localparam logic [4:0] OP_SW   = 5'd16;
    localparam logic [4:0] OP_BEQ  = 5'd17;
    localparam logic [4:0] OP_BNE  = 5'd18;
    localparam logic [4:0] OP_JAL  = 5'd19;
    localparam logic [4:0] OP_JALR = 5'd20;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t            state_q, state_d;
    logic              busy_q, done_q, done_d;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       wr_count_q;

    logic [31:0]       fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              start_ok, accept, push, pop;

    // funct3 of the ALU operation, indexed by the R-type op code
    function automatic logic [2:0] alu_f3(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1: alu_f3 = 3'b000;
            3'd2:       alu_f3 = 3'b111;
            3'd3:       alu_f3 = 3'b110;
            3'd4:       alu_f3 = 3'b100;
            3'd5:       alu_f3 = 3'b001;
            default:    alu_f3 = 3'b101;
        endcase
    endfunction

    // Instruction packing; unknown op codes flag enc_ok low
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b1;
        if (bus.req_op < OP_ADDI) begin
            enc_word = {((bus.req_op == OP_SUB) || (bus.req_op == OP_SRA)) ? F7_ALT : 7'b0,
                        bus.req_rs2, bus.req_rs1, alu_f3(bus.req_op[2:0]), bus.req_rd, OPC_R};
        end else begin
            case (bus.req_op)
                OP_ADDI: enc_word = {bus.req_imm, bus.req_rs1, alu_f3(3'd0), bus.req_rd, OPC_I};
                OP_ANDI: enc_word = {bus.req_imm, bus.req_rs1, alu_f3(3'd2), bus.req_rd, OPC_I};
                OP_ORI:  enc_word = {bus.req_imm, bus.req_rs1, alu_f3(3'd3), bus.req_rd, OPC_I};
                OP_XORI: enc_word = {bus.req_imm, bus.req_rs1, alu_f3(3'd4), bus.req_rd, OPC_I};
                OP_SLLI: enc_word = {7'b0, bus.req_imm[4:0], bus.req_rs1, alu_f3(3'd5),
                                     bus.req_rd, OPC_I};
                OP_SRLI: enc_word = {7'b0, bus.req_imm[4:0], bus.req_rs1, alu_f3(3'd6),
                                     bus.req_rd, OPC_I};
                OP_SRAI: enc_word = {F7_ALT, bus.req_imm[4:0], bus.req_rs1, alu_f3(3'd7),
                                     bus.req_rd, OPC_I};
                OP_LW:   enc_word = {bus.req_imm, bus.req_rs1, 3'b010, bus.req_rd, OPC_LW};
                OP_SW:   enc_word = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010,
                                     bus.req_imm[4:0], OPC_SW};
                OP_BEQ:  enc_word = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b000,
                                     bus.req_imm[4:0], OPC_BR};
                OP_BNE:  enc_word = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b001,
                                     bus.req_imm[4:0], OPC_BR};
                OP_JAL:  enc_word = {bus.req_imm, 5'b0, 3'b000, bus.req_rd, OPC_JAL};
                OP_JALR: enc_word = {bus.req_imm, bus.req_rs1, 3'b000, bus.req_rd, OPC_JALR};
                default: enc_ok   = 1'b0;
            endcase
        end
    end

    // Ready is a function of occupancy only, so a full FIFO never takes a push
    assign bus.req_ready  = (state_q == S_RUN) && (count_q < CNT_W'(DEPTH));
    assign accept         = bus.req_valid && bus.req_ready;
    assign push           = accept && enc_ok;
    assign bus.imem_we    = (count_q != '0);
    assign pop            = bus.imem_we && bus.imem_ready;
    assign bus.imem_wdata = fifo_mem[rd_ptr_q];
    assign bus.imem_addr  = addr_q;
    assign start_ok       = start && (state_q == S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) fifo_mem[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= enc_word;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (stop) state_d = S_DRAIN;
            S_DRAIN: begin
                if (count_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else if (start_ok) begin
            addr_q     <= base_addr;
            wr_count_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (pop) begin
                addr_q <= addr_q + ADDR_W'(ADDR_STEP);
                if (wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
            end
            if (accept && !enc_ok) err_q <= 1'b1;
        end
    end

`ifdef ENC_CHECKSUM_EN
    logic [31:0] checksum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        checksum_q <= '0;
        else if (start_ok) checksum_q <= '0;
        else if (pop)      checksum_q <= checksum_q ^ bus.imem_wdata;
    end

    assign checksum = checksum_q;
`else
    assign checksum = 32'h0;
`endif

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign wr_count = wr_count_q;
endmodule

// File: tb/tb_instr_encoder_writer.sv
// Directed bench for instr_encoder_writer: encodings, backpressure, invalid ops,
// drain/done, address wrap and asynchronous reset.
module tb_instr_encoder_writer;
    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start, stop;
    logic [ADDR_W-1:0] base_addr;
    logic              busy, done, err;
    logic [15:0]       wr_count;
    logic [31:0]       checksum;

    int checks   = 0;
    int failures = 0;

    logic [ADDR_W-1:0] wa_q [$];
    logic [31:0]       wd_q [$];

    instr_encoder_writer_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_writer #(.ADDR_W(ADDR_W), .DEPTH(2), .ADDR_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .stop(stop),
        .bus(bus), .busy(busy), .done(done), .err(err), .wr_count(wr_count),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    // Record every completed memory write
    always @(posedge clk) begin
        if (rst_n && bus.imem_we && bus.imem_ready) begin
            wa_q.push_back(bus.imem_addr);
            wd_q.push_back(bus.imem_wdata);
        end
    end

    logic [4:0]  m_op  [10] = '{5'd2, 5'd11, 5'd12, 5'd16, 5'd18, 5'd19, 5'd20, 5'd6, 5'd7, 5'd3};
    logic [4:0]  m_rd  [10] = '{5'd1, 5'd7, 5'd2, 5'd31, 5'd0, 5'd1, 5'd1, 5'd4, 5'd4, 5'd1};
    logic [4:0]  m_rs1 [10] = '{5'd2, 5'd8, 5'd3, 5'd2, 5'd1, 5'd9, 5'd5, 5'd5, 5'd5, 5'd1};
    logic [4:0]  m_rs2 [10] = '{5'd3, 5'd0, 5'd0, 5'd3, 5'd2, 5'd9, 5'd0, 5'd6, 5'd6, 5'd1};
    logic [11:0] m_imm [10] = '{12'h000, 12'hFFF, 12'hFE1, 12'h123, 12'h010, 12'h7FF,
                                12'h004, 12'h000, 12'h000, 12'h000};
    logic [31:0] m_exp [10] = '{32'h00317080, 32'hFFF44381, 32'h00119101, 32'h12312183,
                                32'h00209804, 32'h7FF00085, 32'h00428086, 32'h0062D200,
                                32'h4062D200, 32'h0010E080};

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b);
        start = 1'b1; base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic set_req(input logic [4:0] op, rd, rs1, rs2, input logic [11:0] imm);
        bus.req_op = op; bus.req_rd = rd; bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_imm = imm;
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic send(input logic [4:0] op, rd, rs1, rs2, input logic [11:0] imm);
        bit ok = 1'b0;
        set_req(op, rd, rs1, rs2, imm);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = bus.req_ready;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL send_timeout op=%0d not accepted within 50 cycles", op);
        end
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL done_timeout done never pulsed within 50 cycles");
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.imem_we, bus.req_ready, busy, done, err} !== 5'b0 || bus.imem_addr !== '0 ||
            bus.imem_wdata !== 32'h0 || wr_count !== 16'h0 || checksum !== 32'h0) begin
            failures++;
            $display("FAIL reset_state we=%0b rdy=%0b busy=%0b done=%0b err=%0b addr=%h wdata=%h cnt=%0d cks=%h expected all zero",
                     bus.imem_we, bus.req_ready, busy, done, err, bus.imem_addr, bus.imem_wdata,
                     wr_count, checksum);
        end
    endtask

    task automatic test_add();
        clear_log();
        pulse_start(10'h100);
        checks++;
        if (busy !== 1'b1 || bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL run_entry busy=%0b req_ready=%0b expected 1/1", busy, bus.req_ready);
        end
        send(5'd0, 5'd3, 5'd1, 5'd2, 12'h000);
        checks++;
        if (bus.imem_we !== 1'b1 || bus.imem_wdata !== 32'h00208180 || bus.imem_addr !== 10'h100) begin
            failures++;
            $display("FAIL add_latency we=%0b wdata=%h addr=%h expected 1 00208180 100",
                     bus.imem_we, bus.imem_wdata, bus.imem_addr);
        end
        @(negedge clk);
        checks++;
        if (wr_count !== 16'd1 || bus.imem_we !== 1'b0) begin
            failures++;
            $display("FAIL add_count wr_count=%0d we=%0b expected 1 0", wr_count, bus.imem_we);
        end
        pulse_stop();
        wait_done();
    endtask

    task automatic test_sub_addi();
        clear_log();
        pulse_start(10'h200);
        send(5'd1, 5'd5, 5'd6, 5'd7, 12'h000);
        send(5'd8, 5'd1, 5'd0, 5'd0, 12'h005);
        pulse_stop();
        wait_done();
        checks++;
        if (wd_q.size() != 2 || wd_q[0] !== 32'h40730280 || wa_q[0] !== 10'h200 ||
            wd_q[1] !== 32'h00500081 || wa_q[1] !== 10'h204 || wr_count !== 16'd2) begin
            failures++;
            $display("FAIL sub_addi n=%0d w0=%h@%h w1=%h@%h cnt=%0d expected 40730280@200 00500081@204 cnt=2",
                     wd_q.size(), wd_q[0], wa_q[0], wd_q[1], wa_q[1], wr_count);
        end
    endtask

    task automatic test_lw_srai();
        clear_log();
        pulse_start(10'h040);
        send(5'd15, 5'd2, 5'd1, 5'd0, 12'h008);
        send(5'd14, 5'd4, 5'd4, 5'd0, 12'h003);
        pulse_stop();
        wait_done();
        checks++;
        if (wd_q.size() != 2 || wd_q[0] !== 32'h0080A102 || wd_q[1] !== 32'h40325201 ||
            wa_q[0] !== 10'h040 || wa_q[1] !== 10'h044) begin
            failures++;
            $display("FAIL lw_srai n=%0d w0=%h@%h w1=%h@%h expected 0080A102@040 40325201@044",
                     wd_q.size(), wd_q[0], wa_q[0], wd_q[1], wa_q[1]);
        end
    endtask

    task automatic test_misc_encodings();
        logic [31:0] cks = 32'h0;
        clear_log();
        pulse_start(10'h000);
        for (int i = 0; i < 10; i++) send(m_op[i], m_rd[i], m_rs1[i], m_rs2[i], m_imm[i]);
        pulse_stop();
        wait_done();
        checks++;
        if (wd_q.size() != 10) begin
            failures++;
            $display("FAIL misc_count writes=%0d expected 10", wd_q.size());
        end
        for (int i = 0; i < 10 && i < wd_q.size(); i++) begin
            checks++;
            if (wd_q[i] !== m_exp[i] || wa_q[i] !== ADDR_W'(4 * i)) begin
                failures++;
                $display("FAIL misc_enc[%0d] op=%0d got %h@%h expected %h@%h", i, m_op[i],
                         wd_q[i], wa_q[i], m_exp[i], ADDR_W'(4 * i));
            end
        end
`ifdef ENC_CHECKSUM_EN
        for (int i = 0; i < 10; i++) cks = cks ^ m_exp[i];
`endif
        checks++;
        if (checksum !== cks) begin
            failures++;
            $display("FAIL checksum got %h expected %h", checksum, cks);
        end
    endtask

    task automatic test_backpressure();
        bit ok = 1'b0;
        clear_log();
        bus.imem_ready = 1'b0;
        pulse_start(10'h300);
        send(5'd0, 5'd3, 5'd1, 5'd2, 12'h000);
        send(5'd1, 5'd5, 5'd6, 5'd7, 12'h000);
        set_req(5'd8, 5'd1, 5'd0, 5'd0, 12'h005);
        bus.req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.req_ready !== 1'b0 || bus.imem_we !== 1'b1 || bus.imem_addr !== 10'h300 ||
                bus.imem_wdata !== 32'h00208180 || wd_q.size() != 0) begin
                failures++;
                $display("FAIL stall[%0d] rdy=%0b we=%0b addr=%h wdata=%h writes=%0d expected 0 1 300 00208180 0",
                         i, bus.req_ready, bus.imem_we, bus.imem_addr, bus.imem_wdata, wd_q.size());
            end
            @(negedge clk);
        end
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = bus.req_ready;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL stall_release third request not accepted");
        end
        pulse_stop();
        wait_done();
        checks++;
        if (wd_q.size() != 3 || wd_q[0] !== 32'h00208180 || wd_q[1] !== 32'h40730280 ||
            wd_q[2] !== 32'h00500081 || wa_q[0] !== 10'h300 || wa_q[1] !== 10'h304 ||
            wa_q[2] !== 10'h308 || wr_count !== 16'd3) begin
            failures++;
            $display("FAIL stall_order n=%0d %h@%h %h@%h %h@%h cnt=%0d expected 00208180@300 40730280@304 00500081@308 cnt=3",
                     wd_q.size(), wd_q[0], wa_q[0], wd_q[1], wa_q[1], wd_q[2], wa_q[2], wr_count);
        end
    endtask

    task automatic test_invalid();
        bit seen = 1'b0;
        clear_log();
        pulse_start(10'h080);
        send(5'd25, 5'd1, 5'd1, 5'd1, 12'h001);
        checks++;
        if (err !== 1'b1 || bus.imem_we !== 1'b0) begin
            failures++;
            $display("FAIL invalid_op err=%0b we=%0b expected 1 0", err, bus.imem_we);
        end
        send(5'd0, 5'd3, 5'd1, 5'd2, 12'h000);
        pulse_stop();
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL drain_busy busy=%0b before done expected 1", busy);
                end
                @(negedge clk);
            end
        end
        checks++;
        if (!seen || busy !== 1'b0 || wd_q.size() != 1) begin
            failures++;
            $display("FAIL done_pulse seen=%0b busy=%0b writes=%0d expected 1 0 1", seen, busy, wd_q.size());
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err !== 1'b1 || wr_count !== 16'd1 || wd_q[0] !== 32'h00208180 ||
            wa_q[0] !== 10'h080) begin
            failures++;
            $display("FAIL invalid_after done=%0b err=%0b cnt=%0d w=%h@%h expected 0 1 1 00208180@080",
                     done, err, wr_count, wd_q[0], wa_q[0]);
        end
    endtask

    task automatic test_stop_with_accept();
        clear_log();
        pulse_start(10'h0C0);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear err=%0b after start expected 0", err);
        end
        set_req(5'd19, 5'd1, 5'd9, 5'd9, 12'h7FF);
        bus.req_valid = 1'b1;
        stop = 1'b1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL stop_accept_rdy req_ready=%0b expected 1", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.imem_we !== 1'b1 || bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL stop_accept_drain busy=%0b we=%0b rdy=%0b expected 1 1 0",
                     busy, bus.imem_we, bus.req_ready);
        end
        wait_done();
        checks++;
        if (wd_q.size() != 1 || wd_q[0] !== 32'h7FF00085 || wa_q[0] !== 10'h0C0) begin
            failures++;
            $display("FAIL stop_accept_word n=%0d w=%h@%h expected 7FF00085@0C0",
                     wd_q.size(), wd_q[0], wa_q[0]);
        end
    endtask

    task automatic test_wrap();
        clear_log();
        pulse_start(10'h3FC);
        send(5'd0, 5'd3, 5'd1, 5'd2, 12'h000);
        send(5'd1, 5'd5, 5'd6, 5'd7, 12'h000);
        pulse_stop();
        wait_done();
        checks++;
        if (wd_q.size() != 2 || wa_q[0] !== 10'h3FC || wa_q[1] !== 10'h000 ||
            bus.imem_addr !== 10'h004) begin
            failures++;
            $display("FAIL addr_wrap n=%0d a0=%h a1=%h next=%h expected 3FC 000 004",
                     wd_q.size(), wa_q[0], wa_q[1], bus.imem_addr);
        end
    endtask

    task automatic test_reset_midwrite();
        bus.imem_ready = 1'b0;
        pulse_start(10'h010);
        send(5'd0, 5'd3, 5'd1, 5'd2, 12'h000);
        checks++;
        if (bus.imem_we !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset we=%0b busy=%0b expected 1 1", bus.imem_we, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.imem_we !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 1'b0 ||
            bus.imem_addr !== '0 || bus.imem_wdata !== 32'h0 || wr_count !== 16'h0) begin
            failures++;
            $display("FAIL async_reset we=%0b busy=%0b rdy=%0b addr=%h wdata=%h cnt=%0d expected all zero",
                     bus.imem_we, busy, bus.req_ready, bus.imem_addr, bus.imem_wdata, wr_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.imem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_we !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset we=%0b busy=%0b expected 0 0", bus.imem_we, busy);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; base_addr = '0;
        bus.req_valid = 1'b0; bus.imem_ready = 1'b1;
        set_req(5'd0, 5'd0, 5'd0, 5'd0, 12'h000);
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub_addi();
        test_lw_srai();
        test_misc_encodings();
        test_backpressure();
        test_invalid();
        test_stop_with_accept();
        test_wrap();
        test_reset_midwrite();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_encoder_writer.md
Name: instr_encoder_writer

Overview:
- Encoder counterpart to the control-unit/ALU-control decoder.
- Accepts mnemonic-level instruction requests over a valid/ready handshake and packs each into a 32-bit instruction word in the decoder's field layout.
- Buffers encoded words in a small FIFO and writes them sequentially into instruction memory from a programmable base address.
- Used by the bench/boot path to load programs.

Parameters:
- ADDR_W, 10, instruction memory byte-address width.
- DEPTH, 2, encoded-word FIFO depth (power of 2, ≥2).
- ADDR_STEP, 4, address increment per written word.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse: load base_addr, enter RUN (ignored unless IDLE)
- base_addr  in  ADDR_W  first write address
- stop  in  1  1-cycle pulse: stop accepting, drain FIFO (ignored unless RUN)
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&&ready
- req_op  in  5  operation code (see Behaviour)
- req_rd  in  5  destination register
- req_rs1  in  5  source 1
- req_rs2  in  5  source 2
- req_imm  in  12  immediate (shamt = imm[4:0] for shifts)
- imem_we  out  1  write strobe, held until imem_ready
- imem_ready  in  1  memory accepts write when imem_we&&imem_ready
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  32  encoded word
- busy  out  1  state != IDLE
- done  out  1  1-cycle pulse when DRAIN completes
- err  out  1  sticky invalid-op flag, cleared by start
- wr_count  out  16  words written since start, saturates at 16'hFFFF
- checksum  out  32  see Optional Feature

Behaviour:
- Word layout:
  - [31:25] funct7, [24:20] rs2, [19:15] rs1, [14:12] funct3, [11:7] rd, [6:0] opcode.
- R-type (opcode 7'h00): req_op 0..7 = ADD, SUB, AND, OR, XOR, SLL, SRL, SRA.
  - funct3 = 000, 000, 111, 110, 100, 001, 101, 101.
  - funct7 = 7'b0100000 for SUB and SRA, else 0.
- I-type (opcode 7'h01): req_op 8..14 = ADDI, ANDI, ORI, XORI, SLLI, SRLI, SRAI.
  - funct3 as for the R-type counterpart.
  - [31:20] = imm, except shifts: [24:20] = imm[4:0] and [31:25] = funct7 (0100000 for SRAI, else 0).
- LW, req_op 15: opcode 7'h02, funct3 010, imm at [31:20], rs1, rd.
- SW, req_op 16: opcode 7'h03, funct3 010, imm[11:5] at [31:25], imm[4:0] at [11:7], rs1, rs2.
- BEQ/BNE, req_op 17/18: opcode 7'h04, funct3 000/001, imm split as SW, rs1, rs2.
- JAL, req_op 19: opcode 7'h05, imm at [31:20], rd; all other fields 0.
- JALR, req_op 20: opcode 7'h06, funct3 000, imm at [31:20], rs1, rd.
- req_op 21..31 is invalid:
  - request is consumed (handshake completes), no word pushed, err set.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE→RUN on start: addr ← base_addr, wr_count ← 0, err ← 0, checksum ← 0.
  - RUN→DRAIN on stop.
  - DRAIN→IDLE when FIFO empty and no write pending; done pulses that cycle.
  - start in RUN/DRAIN ignored. stop in IDLE/DRAIN ignored.
- Handshake:
  - req_ready = (state==RUN) && (fifo_count < DEPTH).
  - Computed from count only: no push when full even if a pop occurs the same cycle.
  - req_ready does not depend on req_valid.
- Latency: accepted request → encoded word in FIFO at the next edge → imem_we high the following cycle (1 cycle min accept-to-we).
- Memory write interface:
  - imem_we = FIFO non-empty.
  - imem_addr / imem_wdata driven from the FIFO head and stable while imem_we && !imem_ready.
  - On completed write: pop, addr += ADDR_STEP (wraps modulo 2^ADDR_W), wr_count += 1 (saturating).
- Simultaneous push and pop: both occur; count unchanged.
- stop and the last accept in the same cycle: the request is accepted and drained.
- Reset, asynchronous, any time:
  - FIFO emptied; state IDLE.
  - All outputs 0, including imem_we, imem_addr, imem_wdata, done, err, wr_count, checksum.

Optional Feature:
- Macro ENC_CHECKSUM_EN.
- Defined: checksum ← checksum XOR imem_wdata on each completed write; cleared on start.
- Undefined: checksum tied to 32'h0 and no accumulator register.

Test Plan:
- start with base_addr=0x100, then ADD rd=3 rs1=1 rs2=2 → write 0x00208180 @0x100; wr_count=1.
- SUB rd=5 rs1=6 rs2=7 then ADDI rd=1 rs1=0 imm=0x005 → 0x40730280 @base, 0x00500081 @base+4.
- LW rd=2 rs1=1 imm=8 and SRAI rd=4 rs1=4 imm=3 → 0x0080A102, 0x40325201.
- Hold imem_ready=0 for 5 cycles with 3 requests:
  - req_ready drops after 2 accepts.
  - imem_addr/imem_wdata stable.
  - All 3 written in order after release.
- req_op=25, then ADD, then stop:
  - err=1, only one write.
  - done pulses once FIFO is empty; busy falls the same cycle.
- base_addr=0x3FC with ADDR_W=10, two writes → addresses 0x3FC then 0x000. Assert rst_n low mid-write → imem_we=0, busy=0 immediately.
